axis_inverter_block: RTL and testbench

AXIS_INVERTER_BLOCK -- requirements
Module: axis_inverter

---
 rtl/axis_inverter_block.sv | 87 ++++++++
 tb/tb_axis_inverter_block.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/axis_inverter_block.sv
// axis_inverter_block
//   AXI-Stream bitwise inverter built as a 2-entry register slice: one output
//   register driving m_axis_*, plus one skid register that holds a beat that
//   arrives while the output is stalled. Every output comes straight from a flop.
//
// Ports
//   clk            clock, rising edge
//   rst_n          synchronous active-low reset; it clears both registers
//   s_axis_tdata   upstream data
//   s_axis_tvalid  upstream valid
//   s_axis_tlast   upstream end-of-packet marker
//   s_axis_tready  registered; high when the skid register is empty
//   m_axis_tdata   inverted data (~s_axis_tdata)
//   m_axis_tvalid  downstream valid
//   m_axis_tlast   downstream end-of-packet marker (passed through)
//   m_axis_tready  downstream ready
module axis_inverter_block #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready
);

  logic [DATA_WIDTH-1:0] skid_data;
  logic                  skid_last;
  logic                  skid_valid;

  logic in_hs;
  logic load_out;
  logic skid_valid_nxt;

  assign in_hs    = s_axis_tvalid && s_axis_tready;
  // The output register can take a new beat when it is empty or draining now.
  assign load_out = !m_axis_tvalid || m_axis_tready;

  // The next skid occupancy is computed ahead of time so that s_axis_tready
  // can be a flop and still track the skid state without a cycle of lag.
  always_comb begin
    skid_valid_nxt = skid_valid;
    if (load_out)
      skid_valid_nxt = 1'b0;
    else if (in_hs)
      skid_valid_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      skid_data     <= '0;
      skid_last     <= 1'b0;
      skid_valid    <= 1'b0;
      s_axis_tready <= 1'b0;
    end else begin
      skid_valid    <= skid_valid_nxt;
      s_axis_tready <= !skid_valid_nxt;
      if (load_out) begin
        // The skid beat is older than anything on the input, so it goes first.
        // An input handshake cannot coincide with a full skid register.
        if (skid_valid) begin
          m_axis_tdata  <= skid_data;
          m_axis_tlast  <= skid_last;
          m_axis_tvalid <= 1'b1;
        end else if (in_hs) begin
          m_axis_tdata  <= ~s_axis_tdata;
          m_axis_tlast  <= s_axis_tlast;
          m_axis_tvalid <= 1'b1;
        end else begin
          m_axis_tvalid <= 1'b0;
        end
      end else if (in_hs) begin
        skid_data <= ~s_axis_tdata;
        skid_last <= s_axis_tlast;
      end
    end
  end

endmodule

// File: tb/tb_axis_inverter_block.sv
module tb_axis_inverter_block;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axis_inverter_block #(.DATA_WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready)
  );

  typedef struct {
    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        mready;
    logic        exp_mvalid;
    logic [31:0] exp_mdata;
    logic        exp_mlast;
    logic        exp_sready;
    logic        chk_data;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are read at that point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic l, input logic mr);
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    m_axis_tready = mr;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] bd [10];
    logic        bl [10];
    logic [31:0] q_data [$];
    logic        q_last [$];
    int sent, rcvd;
    logic in_hs, out_hs, stalled;
    logic [31:0] held_data;
    logic        held_last;

    // corner data, then a stall that forces the skid register to fill
    vecs[0] = '{32'h0000_0000, 1, 0, 1, 1, 32'hFFFF_FFFF, 0, 1, 1};
    vecs[1] = '{32'hFFFF_FFFF, 1, 1, 1, 1, 32'h0000_0000, 1, 1, 1};
    vecs[2] = '{32'hAAAA_AAAA, 1, 0, 1, 1, 32'h5555_5555, 0, 1, 1};
    vecs[3] = '{32'h0000_0000, 0, 0, 1, 0, 32'h0000_0000, 0, 1, 0};
    vecs[4] = '{32'h0000_0001, 1, 0, 0, 1, 32'hFFFF_FFFE, 0, 1, 1};
    vecs[5] = '{32'h0000_0002, 1, 1, 0, 1, 32'hFFFF_FFFE, 0, 0, 1};
    vecs[6] = '{32'h0000_0003, 1, 0, 0, 1, 32'hFFFF_FFFE, 0, 0, 1};
    vecs[7] = '{32'h0000_0000, 0, 0, 1, 1, 32'hFFFF_FFFD, 1, 1, 1};
    vecs[8] = '{32'h0000_0000, 0, 0, 1, 0, 32'h0000_0000, 0, 1, 0};

    // reset with traffic present: outputs must stay zero
    rst_n = 1'b0;
    drive(1, 32'h1234_5678, 1, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rst_mvalid", {31'b0, m_axis_tvalid}, 0);
      chk("rst_mdata",  m_axis_tdata, 0);
      chk("rst_mlast",  {31'b0, m_axis_tlast}, 0);
      chk("rst_sready", {31'b0, s_axis_tready}, 0);
    end
    rst_n = 1'b1;
    drive(0, 0, 0, 1);
    step();
    chk("idle_sready", {31'b0, s_axis_tready}, 1);
    chk("idle_mvalid", {31'b0, m_axis_tvalid}, 0);

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].tvalid, vecs[i].tdata, vecs[i].tlast, vecs[i].mready);
      step();
      chk($sformatf("vec%0d_mvalid", i), {31'b0, m_axis_tvalid}, {31'b0, vecs[i].exp_mvalid});
      chk($sformatf("vec%0d_sready", i), {31'b0, s_axis_tready}, {31'b0, vecs[i].exp_sready});
      if (vecs[i].chk_data) begin
        chk($sformatf("vec%0d_mdata", i), m_axis_tdata, vecs[i].exp_mdata);
        chk($sformatf("vec%0d_mlast", i), {31'b0, m_axis_tlast}, {31'b0, vecs[i].exp_mlast});
      end
    end

    // burst of 10 back-to-back beats, 1-cycle latency, ready never drops
    for (int i = 0; i < 10; i++) begin
      bd[i] = $urandom;
      bl[i] = (i == 9);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, bd[i], bl[i], 1);
      step();
      chk("burst_mvalid", {31'b0, m_axis_tvalid}, 1);
      chk("burst_mdata",  m_axis_tdata, ~bd[i]);
      chk("burst_mlast",  {31'b0, m_axis_tlast}, {31'b0, bl[i]});
      chk("burst_sready", {31'b0, s_axis_tready}, 1);
    end
    drive(0, 0, 0, 1);
    step();
    chk("burst_end_mvalid", {31'b0, m_axis_tvalid}, 0);

    // random stress against a scoreboard
    sent = 0;
    rcvd = 0;
    for (int cyc = 0; cyc < 3000 && rcvd < 50; cyc++) begin
      drive((sent < 50) ? 1'($urandom_range(0, 1)) : 1'b0, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      in_hs     = s_axis_tvalid && s_axis_tready;
      out_hs    = m_axis_tvalid && m_axis_tready;
      stalled   = m_axis_tvalid && !m_axis_tready;
      held_data = m_axis_tdata;
      held_last = m_axis_tlast;
      if (out_hs) begin
        if (q_data.size() == 0) begin
          chk("stress_extra_beat", 1, 0);
        end else begin
          chk("stress_data", m_axis_tdata, q_data.pop_front());
          chk("stress_last", {31'b0, m_axis_tlast}, {31'b0, q_last.pop_front()});
        end
        rcvd++;
      end
      if (in_hs) begin
        q_data.push_back(~s_axis_tdata);
        q_last.push_back(s_axis_tlast);
        sent++;
      end
      step();
      if (stalled) begin
        chk("stall_hold_valid", {31'b0, m_axis_tvalid}, 1);
        chk("stall_hold_data",  m_axis_tdata, held_data);
        chk("stall_hold_last",  {31'b0, m_axis_tlast}, {31'b0, held_last});
      end
    end
    chk("stress_count", rcvd, 50);
    chk("stress_leftover", q_data.size(), 0);

    // reset while both registers are full: nothing buffered may emerge
    drive(1, 32'hCAFE_0001, 0, 0);
    step();
    drive(1, 32'hCAFE_0002, 1, 0);
    step();
    chk("full_sready", {31'b0, s_axis_tready}, 0);
    chk("full_mdata",  m_axis_tdata, 32'h3501_FFFE);
    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    step();
    chk("midrst_mvalid", {31'b0, m_axis_tvalid}, 0);
    rst_n = 1'b1;
    drive(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_mvalid", {31'b0, m_axis_tvalid}, 0);
      chk("post_rst_sready", {31'b0, s_axis_tready}, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
